// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using one double-dabble step per clock.
// Results above 99_999_999 saturate to all nines and raise ovf.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
    localparam logic [31:0]      MAX_DEC  = 32'd99_999_999;
    localparam logic [BCD_W-1:0] SAT_BCD  = {DIGITS{4'h9}};

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic               done_q, done_d;

    logic [BCD_W-1:0]   scratch_adj;
    logic [BCD_W:0]     stepped;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        assign scratch_adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5)
                                      ? scratch_q[4*gi +: 4] + 4'd3
                                      : scratch_q[4*gi +: 4];
    end

    // Bit BCD_W is the carry out of the top digit; it can only be set
    // when the value is already past the eight-digit range.
    assign stepped = {scratch_adj, shift_q[BIN_W-1]};

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        ovf_pend_d = ovf_pend_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d    = bin;
                    scratch_d  = '0;
                    cnt_d      = '0;
                    ovf_pend_d = (32'(bin) > MAX_DEC);
                    state_d    = CONV;
                end
            end
            CONV: begin
                scratch_d  = stepped[BCD_W-1:0];
                shift_d    = shift_q << 1;
                cnt_d      = cnt_q + CNT_W'(1);
                ovf_pend_d = ovf_pend_q | stepped[BCD_W];
                if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    ovf_d   = ovf_pend_d;
                    bcd_d   = ovf_pend_d ? SAT_BCD : stepped[BCD_W-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            ovf_pend_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            ovf_pend_q <= ovf_pend_d;
            done_q     <= done_d;
        end
    end

    assign busy = (state_q == CONV);
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: vector table, protocol/reset sequences and a
// short random sweep against a division-based decimal reference.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [26:0] bin = '0;
    logic        busy;
    logic        done;
    logic [31:0] bcd;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    bin_to_bcd_seq #(.BIN_W(27), .DIGITS(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [26:0] bin;
        logic [31:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_bcd(input int unsigned v);
        logic [31:0] r;
        int unsigned x;
        if (v > 99_999_999) return 32'h9999_9999;
        r = '0;
        x = v;
        for (int d = 0; d < 8; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Accept v on the next edge, then wait (bounded) for done.
    // lat counts edges after the accept edge; busy_cnt counts sampled busy cycles.
    task automatic convert(input logic [26:0] v, output int lat, output int busy_cnt,
                           output int clash);
        bin   = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        clash    = 0;
        while (!done && lat < 60) begin
            tick();
            lat++;
            if (busy) busy_cnt++;
            if (busy && done) clash++;
        end
    endtask

    initial begin
        int lat, bcnt, clash, dcnt;
        logic [26:0] rv;

        vecs[0]  = '{27'd0,           32'h0000_0000, 1'b0};
        vecs[1]  = '{27'd12_345_678,  32'h1234_5678, 1'b0};
        vecs[2]  = '{27'd99_999_999,  32'h9999_9999, 1'b0};
        vecs[3]  = '{27'd100_000_000, 32'h9999_9999, 1'b1};
        vecs[4]  = '{27'd134_217_727, 32'h9999_9999, 1'b1};
        vecs[5]  = '{27'd1,           32'h0000_0001, 1'b0};
        vecs[6]  = '{27'd9,           32'h0000_0009, 1'b0};
        vecs[7]  = '{27'd10,          32'h0000_0010, 1'b0};
        vecs[8]  = '{27'd99,          32'h0000_0099, 1'b0};
        vecs[9]  = '{27'd555,         32'h0000_0555, 1'b0};
        vecs[10] = '{27'd1_000_000,   32'h0100_0000, 1'b0};
        vecs[11] = '{27'd87_654_321,  32'h8765_4321, 1'b0};
        vecs[12] = '{27'd50_000_000,  32'h5000_0000, 1'b0};
        vecs[13] = '{27'd109_999_999, 32'h9999_9999, 1'b1};

        // Reset state
        repeat (3) tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bcd",  bcd,       32'd0);
        check("reset_ovf",  32'(ovf),  32'd0);
        rst = 1'b1;
        tick();

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            convert(vecs[i].bin, lat, bcnt, clash);
            $display("vec %0d: bin=%0d bcd=%h ovf=%0b lat=%0d", i, vecs[i].bin, bcd, ovf, lat);
            check("vec_latency", 32'(lat), 32'd27);
            check("vec_bcd",     bcd,      vecs[i].bcd);
            check("vec_ovf",     32'(ovf), 32'(vecs[i].ovf));
            check("vec_busy_cycles", 32'(bcnt), 32'd27);
            check("vec_busy_at_done", 32'(busy), 32'd0);
            check("vec_done_busy_clash", 32'(clash), 32'd0);
            tick();
            check("vec_done_one_cycle", 32'(done), 32'd0);
        end

        // start held high; second request accepted on the done cycle
        bin   = 27'd42;
        start = 1'b1;
        tick();
        lat = 0;
        while (!done && lat < 60) begin
            tick();
            lat++;
        end
        $display("held start first: bcd=%h lat=%0d", bcd, lat);
        check("held_first_lat", 32'(lat), 32'd27);
        check("held_first_bcd", bcd, 32'h0000_0042);
        bin = 27'd7;
        tick();
        start = 1'b0;
        check("held_second_accepted", 32'(busy), 32'd1);
        check("bcd_hold_on_accept", bcd, 32'h0000_0042);
        bin = 27'd99_999_999;
        lat = 1;
        while (!done && lat < 60) begin
            tick();
            lat++;
        end
        $display("held start second: bcd=%h lat=%0d", bcd, lat);
        check("held_second_period", 32'(lat), 32'd28);
        check("held_second_bcd", bcd, 32'h0000_0007);
        tick();

        // Extra start pulses mid-conversion are ignored
        bin   = 27'd1234;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!done && lat < 60) begin
            if (lat % 5 == 2) begin
                bin   = 27'd9_999;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        $display("extra starts: bcd=%h lat=%0d", bcd, lat);
        check("extra_start_lat", 32'(lat), 32'd27);
        check("extra_start_bcd", bcd, 32'h0000_1234);
        tick();
        check("extra_start_no_requeue", 32'(busy), 32'd0);

        // Reset in the middle of a conversion of 555
        bin   = 27'd555;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        #2 rst = 1'b0;
        #1;
        $display("mid reset: busy=%0b done=%0b bcd=%h ovf=%0b", busy, done, bcd, ovf);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_bcd",  bcd,       32'd0);
        check("midrst_ovf",  32'(ovf),  32'd0);
        repeat (2) tick();
        rst = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done) dcnt++;
        end
        check("midrst_no_done", 32'(dcnt), 32'd0);
        convert(27'd555, lat, bcnt, clash);
        $display("after reset: bcd=%h lat=%0d", bcd, lat);
        check("postrst_lat", 32'(lat), 32'd27);
        check("postrst_bcd", bcd, 32'h0000_0555);
        tick();

        // Short random sweep against the decimal reference
        for (int k = 0; k < 120; k++) begin
            rv = (k % 2 == 0) ? 27'($urandom_range(0, 99_999_999))
                              : 27'($urandom_range(0, 134_217_727));
            convert(rv, lat, bcnt, clash);
            $display("rand %0d: bin=%0d bcd=%h ovf=%0b", k, rv, bcd, ovf);
            check("rand_bcd", bcd, ref_bcd(int'(rv)));
            check("rand_ovf", 32'(ovf), (int'(rv) > 99_999_999) ? 32'd1 : 32'd0);
            check("rand_lat", 32'(lat), 32'd27);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
